mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port (req/addr_ok/data_ok) between instruction fetch (read-only) and the MEM stage (ld/st).
//  Holds each grant until its address handshake completes, tracks outstanding transactions in issue order,
//  and routes every data_ok/rdata back to the master that issued it. Sits between the core pipeline and the cpu bridge.
// PARAMETERS
//  MAX_OUTST    2  max accepted-but-not-returned transactions (FIFO depth, >=1)
//  STARVE_LIM   4  consecutive data grants while inst_req pending before inst is forced a grant
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   reset, asynchronous, active-low (0 = reset)
//  inst_req      in   1   fetch request (read)
//  inst_addr     in   32  fetch address
//  inst_addr_ok  out  1   fetch request accepted this cycle
//  inst_data_ok  out  1   fetch data returned this cycle
//  inst_rdata    out  32  fetch data (valid with inst_data_ok)
//  data_req      in   1   MEM-stage request
//  data_wr       in   1   1 = store, 0 = load
//  data_size     in   2   0 byte, 1 half, 2 word
//  data_wstrb    in   4   store byte enables
//  data_addr     in   32  load/store address
//  data_wdata    in   32  store data, already lane-replicated
//  data_addr_ok  out  1   MEM request accepted this cycle
//  data_data_ok  out  1   load data / store completion this cycle
//  data_rdata    out  32  raw load word (MEM stage extracts/extends)
//  mem_req mem_wr mem_size mem_wstrb mem_addr mem_wdata  out 1/1/2/4/32/32  shared port request
//  mem_addr_ok   in   1   port accepted request
//  mem_data_ok   in   1   port returns data/completion, in issue order
//  mem_rdata     in   32  port read data
//  arb_err       out  1   sticky: mem_data_ok with no outstanding transaction
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, FIFO empty, starve_cnt=0, arb_err=0; all outputs 0.
//  FSM: IDLE, HOLD_I, HOLD_D (registered grant owner).
//   IDLE: if FIFO full -> no grant, mem_req=0. Else pick: data_req wins unless inst_req && starve_cnt==STARVE_LIM.
//     Picked master drives mem_* combinationally, mem_req=1 same cycle (0-cycle arbitration).
//     If mem_addr_ok same cycle -> push owner id, stay IDLE; else -> HOLD_x.
//   HOLD_x: mem_* driven from owner x only, ignoring the other master; on mem_addr_ok push id -> IDLE.
//     A master's request is stable until its addr_ok; arbiter never switches owner mid-handshake.
//  inst path: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
//  x_addr_ok = mem_addr_ok && mem_req && owner==x; never asserted for the non-owner.
//  starve_cnt: +1 (saturating at STARVE_LIM) on data accept while inst_req=1; cleared on inst accept or inst_req=0.
//  Order FIFO: MAX_OUTST x 1-bit ids, ptrs wrap mod MAX_OUTST, count 0..MAX_OUTST.
//   push on accepted request; pop on mem_data_ok; both same cycle -> count unchanged.
//   Full check uses registered count: push blocked when full even if a pop happens that cycle.
//  Return: mem_data_ok & !empty -> head id selects x_data_ok=1, x_rdata=mem_rdata, same cycle (0 latency);
//   non-selected rdata = 0. mem_data_ok & empty -> no data_ok, arb_err<=1 (cleared only by reset).
//  Store completions pop the FIFO and pulse data_data_ok like loads.
//  Reset mid-transaction: all tracking discarded; the memory side is reset together.
// STRUCTURE
//  Shared package/header: owner ids (ID_INST=0, ID_DATA=1), FSM encodings, size codes (SZ_B/H/W).
//  One sub-module: arb_order_fifo (parameterised id FIFO, push/pop/full/empty/head).
//  Top holds FSM, starvation counter, mux and return demux.
// TESTING
//  1 inst_req only, addr 0x1c000000, mem_addr_ok same cycle, data_ok 2 cycles later rdata 0x02800c0c
//    -> inst_addr_ok cycle0, inst_data_ok+inst_rdata=0x02800c0c cycle2, data side silent.
//  2 inst_req and data_req (ld.w 0x100) same cycle -> data granted first; inst granted next cycle; returns routed in order D,I.
//  3 data_req held 6 cycles with inst_req pending, mem_addr_ok always 1, STARVE_LIM=4 -> 4 data grants, then 1 inst grant.
//  4 mem_addr_ok delayed 3 cycles on data grant while inst_req rises -> mem_* stay on data (HOLD_D), no inst_addr_ok until after.
//  5 MAX_OUTST=2, two accepts with no data_ok -> mem_req=0 on 3rd; data_ok+pending req same cycle -> push waits one cycle.
//  6 st.b 0x103, wstrb 4'b1000 -> mem_wr=1 mem_size=0 mem_wstrb=4'b1000 passed through; spurious mem_data_ok when empty
//    -> arb_err=1, no x_data_ok; async rst=0 mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: master ids, grant FSM encoding
// and access size codes.
package mem_port_arbiter_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_order_fifo.sv
// Issue-order FIFO of 1-bit master ids; one entry per accepted, not yet returned
// memory transaction.
module arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = ids[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the MEM stage, holding each
// grant through its address handshake and routing returns back in issue order.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err,
    output logic [1:0]  arb_state
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          gnt_valid;
    logic          gnt_id;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic          ret_valid;

    // Handshake: a request (x_req with its fields) stays stable until x_addr_ok; a
    // transfer happens in the cycle where mem_req and mem_addr_ok are both high.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ID_DATA;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_full) begin
                    if (data_req && !(inst_req && starve_cnt == STARVE_MAX)) begin
                        gnt_valid = 1'b1;
                        gnt_id    = ID_DATA;
                    end else if (inst_req) begin
                        gnt_valid = 1'b1;
                        gnt_id    = ID_INST;
                    end
                end
                if (gnt_valid && !mem_addr_ok) begin
                    state_nxt = (gnt_id == ID_INST) ? ST_HOLD_I : ST_HOLD_D;
                end
            end
            ST_HOLD_I: begin
                gnt_valid = 1'b1;
                gnt_id    = ID_INST;
                if (mem_addr_ok) state_nxt = ST_IDLE;
            end
            ST_HOLD_D: begin
                gnt_valid = 1'b1;
                gnt_id    = ID_DATA;
                if (mem_addr_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Outputs are forced quiet while reset is held, not only after the next edge.
        if (!rst) gnt_valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (gnt_valid) begin
            mem_req = 1'b1;
            if (gnt_id == ID_INST) begin
                mem_size = SZ_W;
                mem_addr = inst_addr;
            end else begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end
        end
    end

    assign accept       = gnt_valid && mem_addr_ok;
    assign inst_addr_ok = accept && (gnt_id == ID_INST);
    assign data_addr_ok = accept && (gnt_id == ID_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!inst_req || inst_addr_ok) begin
            starve_cnt <= '0;
        end else if (data_addr_ok && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    arb_order_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (gnt_id),
        .pop     (mem_data_ok),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign ret_valid    = mem_data_ok && !fifo_empty;
    assign inst_data_ok = ret_valid && (fifo_head == ID_INST);
    assign data_data_ok = ret_valid && (fifo_head == ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

    // A return with nothing outstanding means the port and arbiter disagree; latch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           arb_err <= 1'b0;
        else if (mem_data_ok && fifo_empty) arb_err <= 1'b1;
    end

    assign arb_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, starvation limit, hold,
// FIFO-full back-pressure, store pass-through, error flag and async reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_err;
    logic [1:0]  arb_state;

    int checks = 0;
    int passes = 0;

    mem_port_arbiter #(
        .MAX_OUTST  (2),
        .STARVE_LIM (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .arb_err      (arb_err),
        .arb_state    (arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        #3;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_arb_err", 32'(arb_err), 32'd0);
        chk("rst_state", 32'(arb_state), 32'd0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // 1: lone fetch, accepted at once, data two cycles later
        inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
        settle();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h1c000000);
        chk("t1_mem_size", 32'(mem_size), 32'd2);
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        settle();
        chk("t1_idle_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h02800c0c;
        settle();
        chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_inst_rdata", inst_rdata, 32'h02800c0c);
        chk("t1_data_silent", 32'({data_data_ok}), 32'd0);
        chk("t1_data_rdata", data_rdata, 32'd0);
        tick();
        mem_data_ok = 1'b0;

        // 2: simultaneous requests, data first, returns in order D then I
        inst_req = 1'b1; inst_addr = 32'h1c000004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h100;
        mem_addr_ok = 1'b1;
        settle();
        chk("t2_data_first", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_wait", 32'(inst_addr_ok), 32'd0);
        chk("t2_addr_d", mem_addr, 32'h100);
        tick();
        data_req = 1'b0;
        settle();
        chk("t2_inst_next", 32'(inst_addr_ok), 32'd1);
        chk("t2_addr_i", mem_addr, 32'h1c000004);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'haaaa0001;
        settle();
        chk("t2_ret_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
        chk("t2_rdata_d", data_rdata, 32'haaaa0001);
        tick();
        mem_rdata = 32'hbbbb0002;
        settle();
        chk("t2_ret_i", 32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("t2_rdata_i", inst_rdata, 32'hbbbb0002);
        tick();
        mem_data_ok = 1'b0;

        // 3: starvation limit, 4 data grants then the fetch is forced in
        data_req = 1'b1; data_addr = 32'h200;
        inst_req = 1'b1; inst_addr = 32'h1c000008;
        mem_addr_ok = 1'b1; mem_rdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            mem_data_ok = (i > 0);
            settle();
            chk($sformatf("t3_grant_%0d", i), 32'({inst_addr_ok, data_addr_ok}),
                (i == 4) ? 32'b10 : 32'b01);
            tick();
        end
        data_req = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t3_drain", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 1'b0;

        // 4: delayed address handshake keeps the port on the data master
        data_req = 1'b1; data_addr = 32'h300; mem_addr_ok = 1'b0;
        settle();
        chk("t4_req", 32'(mem_req), 32'd1);
        chk("t4_no_ok", 32'(data_addr_ok), 32'd0);
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c00000c;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("t4_hold_addr_%0d", i), mem_addr, 32'h300);
            chk($sformatf("t4_hold_state_%0d", i), 32'(arb_state), 32'd2);
            chk($sformatf("t4_no_inst_%0d", i), 32'(inst_addr_ok), 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        settle();
        chk("t4_accept", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        tick();
        data_req = 1'b0;
        settle();
        chk("t4_inst_after", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 1'b0;

        // 5: FIFO full (D,I outstanding) blocks the next grant
        data_req = 1'b1; data_addr = 32'h400; mem_addr_ok = 1'b1;
        settle();
        chk("t5_full_req", 32'(mem_req), 32'd0);
        chk("t5_full_ok", 32'(data_addr_ok), 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h11112222;
        settle();
        chk("t5_pop_noreq", 32'(mem_req), 32'd0);
        chk("t5_pop_ret", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("t5_push_late", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t5_ret_i", 32'({inst_data_ok, data_data_ok}), 32'b10);
        tick();
        settle();
        chk("t5_ret_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
        tick();
        mem_data_ok = 1'b0;

        // 6: store byte pass-through, spurious return, async reset mid-hold
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b1000;
        data_addr = 32'h103; data_wdata = 32'h55555555; mem_addr_ok = 1'b1;
        settle();
        chk("t6_wr", 32'(mem_wr), 32'd1);
        chk("t6_size", 32'(mem_size), 32'd0);
        chk("t6_wstrb", 32'(mem_wstrb), 32'h8);
        chk("t6_addr", mem_addr, 32'h103);
        chk("t6_wdata", mem_wdata, 32'h55555555);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t6_st_done", 32'(data_data_ok), 32'd1);
        tick();
        settle();
        chk("t6_spurious", 32'({inst_data_ok, data_data_ok}), 32'b00);
        chk("t6_err_pre", 32'(arb_err), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        chk("t6_err", 32'(arb_err), 32'd1);
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h500;
        tick();
        settle();
        chk("t6_hold", 32'(arb_state), 32'd2);
        rst = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_addr", mem_addr, 32'd0);
        chk("t6_rst_state", 32'(arb_state), 32'd0);
        chk("t6_rst_err", 32'(arb_err), 32'd0);
        data_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_post_err", 32'(arb_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
